// File: rtl/vdma_pkg.sv
// Shared AXI constants and state encoding for the video DMA read and write cores.
package vdma_pkg;

    localparam logic [1:0] BURST_INCR       = 2'b01;
    localparam logic [3:0] CACHE_BUFFERABLE = 4'b0001;
    localparam logic [2:0] PROT_ZERO        = 3'b000;
    localparam logic       LOCK_ZERO        = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vdma_state_t;

endpackage

// File: rtl/vdma_hv_counter.sv
// Loadable h/v down-counter; h counts in units of h_step and flags the last unit of a line / frame.
module vdma_hv_counter #(
    parameter int H_WIDTH = 12,
    parameter int V_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [H_WIDTH-1:0] h_len,
    input  logic [H_WIDTH-1:0] h_step,
    input  logic [V_WIDTH-1:0] v_len,
    output logic               line_last,
    output logic               frame_last
);

    logic [H_WIDTH-1:0] h_rem;
    logic [V_WIDTH-1:0] v_rem;

    // h_rem holds the units still to go in the current line, including the current one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_rem <= '0;
            v_rem <= '0;
        end else if (load) begin
            h_rem <= h_len;
            v_rem <= v_len;
        end else if (step) begin
            if (line_last) begin
                h_rem <= h_len;
                v_rem <= v_rem - V_WIDTH'(1);
            end else begin
                h_rem <= h_rem - h_step;
            end
        end
    end

    assign line_last  = (h_rem == h_step);
    assign frame_last = line_last && (v_rem == V_WIDTH'(1));

endmodule

// File: rtl/vdma_axi4_to_axi4s_core.sv
// Read-side video DMA: fetches a 2-D frame over AXI4 reads and emits it as an AXI4-Stream video stream.
//  state | meaning
//  IDLE  | no frame armed; waits for ctl_enable
//  RUN   | frame in flight; restarts or idles once AR and R engines are both done
module vdma_axi4_to_axi4s_core
    import vdma_pkg::*;
#(
    parameter int AXI4_ID_WIDTH    = 6,
    parameter int AXI4_ADDR_WIDTH  = 32,
    parameter int AXI4_DATA_SIZE   = 2,
    parameter int AXI4_DATA_WIDTH  = 8 << AXI4_DATA_SIZE,
    parameter int AXI4_LEN_WIDTH   = 8,
    parameter int AXI4_QOS_WIDTH   = 4,
    parameter int AXI4S_USER_WIDTH = 1,
    parameter int STRIDE_WIDTH     = 14,
    parameter int INDEX_WIDTH      = 8,
    parameter int H_WIDTH          = 12,
    parameter int V_WIDTH          = 12
) (
    input  logic                        aresetn,
    input  logic                        aclk,

    input  logic                        ctl_enable,
    input  logic                        ctl_update,
    output logic                        ctl_busy,
    output logic [INDEX_WIDTH-1:0]      ctl_index,

    input  logic [AXI4_ADDR_WIDTH-1:0]  param_addr,
    input  logic [STRIDE_WIDTH-1:0]     param_stride,
    input  logic [H_WIDTH-1:0]          param_width,
    input  logic [V_WIDTH-1:0]          param_height,
    input  logic [AXI4_LEN_WIDTH-1:0]   param_arlen,

    output logic [AXI4_ADDR_WIDTH-1:0]  monitor_addr,
    output logic [STRIDE_WIDTH-1:0]     monitor_stride,
    output logic [H_WIDTH-1:0]          monitor_width,
    output logic [V_WIDTH-1:0]          monitor_height,
    output logic [AXI4_LEN_WIDTH-1:0]   monitor_arlen,

    output logic [AXI4_ID_WIDTH-1:0]    m_axi4_arid,
    output logic [AXI4_ADDR_WIDTH-1:0]  m_axi4_araddr,
    output logic [1:0]                  m_axi4_arburst,
    output logic [3:0]                  m_axi4_arcache,
    output logic [AXI4_LEN_WIDTH-1:0]   m_axi4_arlen,
    output logic                        m_axi4_arlock,
    output logic [2:0]                  m_axi4_arprot,
    output logic [AXI4_QOS_WIDTH-1:0]   m_axi4_arqos,
    output logic [3:0]                  m_axi4_arregion,
    output logic [2:0]                  m_axi4_arsize,
    output logic                        m_axi4_arvalid,
    input  logic                        m_axi4_arready,

    input  logic [AXI4_ID_WIDTH-1:0]    m_axi4_rid,
    input  logic [1:0]                  m_axi4_rresp,
    input  logic [AXI4_DATA_WIDTH-1:0]  m_axi4_rdata,
    input  logic                        m_axi4_rlast,
    input  logic                        m_axi4_rvalid,
    output logic                        m_axi4_rready,

    output logic [AXI4S_USER_WIDTH-1:0] m_axi4s_tuser,
    output logic                        m_axi4s_tlast,
    output logic [AXI4_DATA_WIDTH-1:0]  m_axi4s_tdata,
    output logic                        m_axi4s_tvalid,
    input  logic                        m_axi4s_tready
);

    vdma_state_t state, state_next;
    logic        start_frame, arm, update_pending, ar_done, r_done;

    logic [AXI4_ADDR_WIDTH-1:0] reg_addr;
    logic [STRIDE_WIDTH-1:0]    reg_stride;
    logic [H_WIDTH-1:0]         reg_width;
    logic [V_WIDTH-1:0]         reg_height;
    logic [AXI4_LEN_WIDTH-1:0]  reg_arlen;
    logic [INDEX_WIDTH-1:0]     index;

    logic [AXI4_ADDR_WIDTH-1:0] araddr, line_base, burst_bytes, stride_ext;
    logic [H_WIDTH-1:0]         burst_beats;
    logic                       arvalid, ar_fire, ar_line_last, ar_frame_last;

    logic                       tvalid, tuser, tlast, first, r_fire, rready;
    logic                       r_line_last, r_frame_last;
    logic [AXI4_DATA_WIDTH-1:0] tdata;

    logic unused_inputs;
    assign unused_inputs = ^{m_axi4_rid, m_axi4_rresp, m_axi4_rlast};

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctl_enable) begin
                    state_next  = ST_RUN;
                    start_frame = 1'b1;
                end
            end
            ST_RUN: begin
                if (ar_done && r_done) begin
                    if (ctl_enable) start_frame = 1'b1;
                    else            state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // An update request seen mid-frame is remembered until the next frame start consumes it
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            arm            <= 1'b0;
            update_pending <= 1'b0;
            index          <= '0;
            reg_addr       <= '0;
            reg_stride     <= '0;
            reg_width      <= '0;
            reg_height     <= '0;
            reg_arlen      <= '0;
        end else begin
            state <= state_next;
            arm   <= start_frame;
            if (start_frame) begin
                index          <= index + INDEX_WIDTH'(1);
                update_pending <= 1'b0;
                if (ctl_update || update_pending) begin
                    reg_addr   <= param_addr;
                    reg_stride <= param_stride;
                    reg_width  <= param_width;
                    reg_height <= param_height;
                    reg_arlen  <= param_arlen;
                end
            end else if (ctl_update) begin
                update_pending <= 1'b1;
            end
        end
    end

    assign burst_beats = H_WIDTH'(reg_arlen) + H_WIDTH'(1);
    assign burst_bytes = (AXI4_ADDR_WIDTH'(reg_arlen) + AXI4_ADDR_WIDTH'(1)) << AXI4_DATA_SIZE;
    assign stride_ext  = AXI4_ADDR_WIDTH'(reg_stride);
    assign ar_fire     = arvalid && m_axi4_arready;

    vdma_hv_counter #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_ar_cnt (
        .clk        (aclk),
        .rst_n      (aresetn),
        .load       (arm),
        .step       (ar_fire),
        .h_len      (reg_width),
        .h_step     (burst_beats),
        .v_len      (reg_height),
        .line_last  (ar_line_last),
        .frame_last (ar_frame_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            arvalid   <= 1'b0;
            araddr    <= '0;
            line_base <= '0;
            ar_done   <= 1'b0;
        end else begin
            if (start_frame) ar_done <= 1'b0;
            else if (ar_fire && ar_frame_last) ar_done <= 1'b1;

            if (arm) begin
                arvalid   <= 1'b1;
                araddr    <= reg_addr;
                line_base <= reg_addr;
            end else if (ar_fire) begin
                if (ar_frame_last) begin
                    arvalid <= 1'b0;
                end else if (ar_line_last) begin
                    araddr    <= line_base + stride_ext;
                    line_base <= line_base + stride_ext;
                end else begin
                    araddr <= araddr + burst_bytes;
                end
            end
        end
    end

    assign rready = !tvalid || m_axi4s_tready;
    assign r_fire = m_axi4_rvalid && rready && (state == ST_RUN) && !r_done;

    vdma_hv_counter #(.H_WIDTH(H_WIDTH), .V_WIDTH(V_WIDTH)) u_r_cnt (
        .clk        (aclk),
        .rst_n      (aresetn),
        .load       (arm),
        .step       (r_fire),
        .h_len      (reg_width),
        .h_step     (H_WIDTH'(1)),
        .v_len      (reg_height),
        .line_last  (r_line_last),
        .frame_last (r_frame_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tvalid <= 1'b0;
            tdata  <= '0;
            tuser  <= 1'b0;
            tlast  <= 1'b0;
            first  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            if (start_frame) r_done <= 1'b0;
            else if (r_fire && r_frame_last) r_done <= 1'b1;

            if (arm) first <= 1'b1;
            else if (r_fire) first <= 1'b0;

            if (r_fire) begin
                tvalid <= 1'b1;
                tdata  <= m_axi4_rdata;
                tuser  <= first;
                tlast  <= r_line_last;
            end else if (m_axi4s_tready) begin
                tvalid <= 1'b0;
            end
        end
    end

    assign ctl_busy        = (state == ST_RUN);
    assign ctl_index       = index;
    assign monitor_addr    = reg_addr;
    assign monitor_stride  = reg_stride;
    assign monitor_width   = reg_width;
    assign monitor_height  = reg_height;
    assign monitor_arlen   = reg_arlen;

    assign m_axi4_arid     = '0;
    assign m_axi4_araddr   = araddr;
    assign m_axi4_arburst  = BURST_INCR;
    assign m_axi4_arcache  = CACHE_BUFFERABLE;
    assign m_axi4_arlen    = reg_arlen;
    assign m_axi4_arlock   = LOCK_ZERO;
    assign m_axi4_arprot   = PROT_ZERO;
    assign m_axi4_arqos    = '0;
    assign m_axi4_arregion = 4'b0000;
    assign m_axi4_arsize   = 3'(AXI4_DATA_SIZE);
    assign m_axi4_arvalid  = arvalid;
    assign m_axi4_rready   = rready;

    assign m_axi4s_tuser   = AXI4S_USER_WIDTH'(tuser);
    assign m_axi4s_tlast   = tlast;
    assign m_axi4s_tdata   = tdata;
    assign m_axi4s_tvalid  = tvalid;

endmodule

// File: tb/tb_vdma_axi4_to_axi4s_core.sv
// Directed bench: AXI4 read slave model returning address-derived data, stream sink, per-scenario checks.
module tb_vdma_axi4_to_axi4s_core;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [31:0] data;
    } beat_t;

    logic        aclk, aresetn;
    logic        ctl_enable, ctl_update, ctl_busy;
    logic [7:0]  ctl_index;
    logic [31:0] param_addr, monitor_addr;
    logic [13:0] param_stride, monitor_stride;
    logic [11:0] param_width, monitor_width, param_height, monitor_height;
    logic [7:0]  param_arlen, monitor_arlen;
    logic [5:0]  arid, rid;
    logic [31:0] araddr, rdata, tdata;
    logic [1:0]  arburst, rresp;
    logic [3:0]  arcache, arqos, arregion;
    logic [7:0]  arlen;
    logic        arlock, arvalid, arready, rlast, rvalid, rready;
    logic [2:0]  arprot, arsize;
    logic [0:0]  tuser;
    logic        tlast, tvalid, tready;

    int          total, bad;
    bit          ar_rand, st_rand;
    logic [31:0] ar_log[$], rq[$], exp_ar[$];
    beat_t       st_log[$], exp_st[$];

    vdma_axi4_to_axi4s_core dut (
        .aresetn(aresetn), .aclk(aclk),
        .ctl_enable(ctl_enable), .ctl_update(ctl_update), .ctl_busy(ctl_busy), .ctl_index(ctl_index),
        .param_addr(param_addr), .param_stride(param_stride), .param_width(param_width),
        .param_height(param_height), .param_arlen(param_arlen),
        .monitor_addr(monitor_addr), .monitor_stride(monitor_stride), .monitor_width(monitor_width),
        .monitor_height(monitor_height), .monitor_arlen(monitor_arlen),
        .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arburst(arburst), .m_axi4_arcache(arcache),
        .m_axi4_arlen(arlen), .m_axi4_arlock(arlock), .m_axi4_arprot(arprot), .m_axi4_arqos(arqos),
        .m_axi4_arregion(arregion), .m_axi4_arsize(arsize), .m_axi4_arvalid(arvalid), .m_axi4_arready(arready),
        .m_axi4_rid(rid), .m_axi4_rresp(rresp), .m_axi4_rdata(rdata), .m_axi4_rlast(rlast),
        .m_axi4_rvalid(rvalid), .m_axi4_rready(rready),
        .m_axi4s_tuser(tuser), .m_axi4s_tlast(tlast), .m_axi4s_tdata(tdata),
        .m_axi4s_tvalid(tvalid), .m_axi4s_tready(tready)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic void build_exp(input logic [31:0] base, input logic [31:0] stride,
                                      input int w, input int h, input int alen);
        beat_t e;
        for (int l = 0; l < h; l++) begin
            for (int b = 0; b < w / (alen + 1); b++)
                exp_ar.push_back(base + 32'(l) * stride + 32'(b * (alen + 1) * 4));
            for (int p = 0; p < w; p++) begin
                e.user = (l == 0 && p == 0);
                e.last = (p == w - 1);
                e.data = mk(base + 32'(l) * stride + 32'(p * 4));
                exp_st.push_back(e);
            end
        end
    endfunction

    function automatic void clear_logs();
        ar_log.delete();
        st_log.delete();
        exp_ar.delete();
        exp_st.delete();
    endfunction

    // AXI read slave and stream sink: drive after negedge, sample handshakes just before posedge
    initial begin
        logic [31:0] dummy;
        rvalid = 1'b0; rdata = '0; rid = '0; rresp = 2'b00; rlast = 1'b0;
        arready = 1'b1; tready = 1'b1;
        forever begin
            @(negedge aclk);
            arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            tready  = st_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rq.size() > 0) begin
                rvalid = 1'b1;
                rdata  = mk(rq[0]);
            end else begin
                rvalid = 1'b0;
            end
            #4;
            if (!aresetn) begin
                rq.delete();
            end else begin
                if (arvalid && arready) begin
                    ar_log.push_back(araddr);
                    for (int i = 0; i <= int'(arlen); i++) rq.push_back(araddr + 32'(i * 4));
                end
                if (rvalid && rready) dummy = rq.pop_front();
                if (tvalid && tready) st_log.push_back({tuser[0], tlast, tdata});
            end
        end
    end

    task automatic set_params(input logic [31:0] a, input logic [13:0] s, input logic [11:0] w,
                              input logic [11:0] h, input logic [7:0] l);
        param_addr = a; param_stride = s; param_width = w; param_height = h; param_arlen = l;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge aclk);
        while ((ctl_busy || tvalid) && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        total++;
        if (ctl_busy || tvalid) begin
            bad++;
            $display("FAIL %s timeout: busy=%0b tvalid=%0b, wanted idle", name, ctl_busy, tvalid);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge aclk);
        total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", ctl_busy); end
        total++; if (ctl_index !== 8'd0) begin bad++; $display("FAIL rst_index got=%0d exp=0", ctl_index); end
        total++; if (arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%0b exp=0", arvalid); end
        total++; if ({tvalid, tuser, tlast} !== 3'b000) begin bad++; $display("FAIL rst_stream got=%b exp=000", {tvalid, tuser, tlast}); end
        total++; if (rready !== 1'b1) begin bad++; $display("FAIL rst_rready got=%0b exp=1", rready); end
        total++; if (araddr !== 32'h0 || tdata !== 32'h0) begin bad++; $display("FAIL rst_regs araddr=%h tdata=%h exp 0", araddr, tdata); end
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        total++; if (ctl_busy !== 1'b0 || arvalid !== 1'b0) begin bad++; $display("FAIL rst_release busy=%0b arvalid=%0b exp 0", ctl_busy, arvalid); end
        total++; if (monitor_addr !== 32'h0 || monitor_width !== 12'h0) begin bad++; $display("FAIL rst_shadow addr=%h width=%h exp 0", monitor_addr, monitor_width); end
    endtask

    task automatic test_basic();
        logic [31:0] hand_ar[4];
        logic [31:0] got;
        beat_t       gb;
        hand_ar[0] = 32'h1000; hand_ar[1] = 32'h1010; hand_ar[2] = 32'h1100; hand_ar[3] = 32'h1110;
        clear_logs();
        set_params(32'h1000, 14'h100, 12'd8, 12'd2, 8'd3);
        build_exp(32'h1000, 32'h100, 8, 2, 3);
        @(negedge aclk); ctl_enable = 1'b1; ctl_update = 1'b1;
        @(negedge aclk); ctl_enable = 1'b0; ctl_update = 1'b0;
        total++; if (ctl_busy !== 1'b1 || arvalid !== 1'b0) begin bad++; $display("FAIL basic_entry busy=%0b arvalid=%0b exp busy=1 arvalid=0", ctl_busy, arvalid); end
        @(negedge aclk);
        total++; if (arvalid !== 1'b1 || araddr !== 32'h1000 || arlen !== 8'd3) begin bad++; $display("FAIL basic_first_ar valid=%0b addr=%h len=%0d exp 1/1000/3", arvalid, araddr, arlen); end
        total++; if (arburst !== 2'b01 || arcache !== 4'b0001 || arsize !== 3'd2 || arprot !== 3'd0) begin bad++; $display("FAIL basic_ar_const burst=%b cache=%b size=%0d prot=%b", arburst, arcache, arsize, arprot); end
        wait_idle("basic_done");
        total++; if (ctl_index !== 8'd1 || monitor_addr !== 32'h1000) begin bad++; $display("FAIL basic_index index=%0d mon_addr=%h exp 1/1000", ctl_index, monitor_addr); end
        total++; if (ar_log.size() != 4 || st_log.size() != 16) begin bad++; $display("FAIL basic_counts ar=%0d beats=%0d exp 4/16", ar_log.size(), st_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < ar_log.size()) ? ar_log[i] : 32'hxxxxxxxx;
            total++; if (got !== hand_ar[i]) begin bad++; $display("FAIL basic_ar[%0d] got=%h exp=%h", i, got, hand_ar[i]); end
        end
        for (int i = 0; i < 16; i++) begin
            gb = (i < st_log.size()) ? st_log[i] : 'x;
            total++; if (gb !== exp_st[i]) begin bad++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, gb, exp_st[i]); end
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] got;
        beat_t       gb;
        clear_logs();
        set_params(32'h1000, 14'h100, 12'd8, 12'd2, 8'd3);
        build_exp(32'h1000, 32'h100, 8, 2, 3);
        ar_rand = 1'b1; st_rand = 1'b1;
        @(negedge aclk); ctl_enable = 1'b1; ctl_update = 1'b1;
        @(negedge aclk); ctl_enable = 1'b0; ctl_update = 1'b0;
        wait_idle("rand_done");
        ar_rand = 1'b0; st_rand = 1'b0;
        total++; if (ar_log.size() != 4 || st_log.size() != 16) begin bad++; $display("FAIL rand_counts ar=%0d beats=%0d exp 4/16", ar_log.size(), st_log.size()); end
        for (int i = 0; i < exp_ar.size(); i++) begin
            got = (i < ar_log.size()) ? ar_log[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_ar[i]) begin bad++; $display("FAIL rand_ar[%0d] got=%h exp=%h", i, got, exp_ar[i]); end
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            gb = (i < st_log.size()) ? st_log[i] : 'x;
            total++; if (gb !== exp_st[i]) begin bad++; $display("FAIL rand_beat[%0d] got=%h exp=%h", i, gb, exp_st[i]); end
        end
    endtask

    task automatic test_single_beat();
        logic [31:0] hand_ar[4];
        logic [31:0] got;
        beat_t       gb;
        hand_ar[0] = 32'h3000; hand_ar[1] = 32'h3004; hand_ar[2] = 32'h3008; hand_ar[3] = 32'h300C;
        clear_logs();
        set_params(32'h3000, 14'h40, 12'd4, 12'd1, 8'd0);
        build_exp(32'h3000, 32'h40, 4, 1, 0);
        @(negedge aclk); ctl_enable = 1'b1; ctl_update = 1'b1;
        @(negedge aclk); ctl_enable = 1'b0; ctl_update = 1'b0;
        wait_idle("single_done");
        total++; if (ar_log.size() != 4 || st_log.size() != 4) begin bad++; $display("FAIL single_counts ar=%0d beats=%0d exp 4/4", ar_log.size(), st_log.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < ar_log.size()) ? ar_log[i] : 32'hxxxxxxxx;
            total++; if (got !== hand_ar[i]) begin bad++; $display("FAIL single_ar[%0d] got=%h exp=%h", i, got, hand_ar[i]); end
            gb = (i < st_log.size()) ? st_log[i] : 'x;
            total++; if (gb !== exp_st[i]) begin bad++; $display("FAIL single_beat[%0d] got=%h exp=%h", i, gb, exp_st[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        beat_t       gb;
        bit          found;
        int          n;
        do_reset();
        clear_logs();
        set_params(32'h1000, 14'h100, 12'd8, 12'd2, 8'd3);
        build_exp(32'h1000, 32'h100, 8, 2, 3);
        build_exp(32'h2000, 32'h100, 8, 2, 3);
        @(negedge aclk); ctl_enable = 1'b1; ctl_update = 1'b1;
        @(negedge aclk); ctl_update = 1'b0;
        total++; if (ctl_index !== 8'd1) begin bad++; $display("FAIL b2b_index1 got=%0d exp=1", ctl_index); end
        repeat (6) @(negedge aclk);
        param_addr = 32'h2000; ctl_update = 1'b1;
        @(negedge aclk); ctl_update = 1'b0;
        n = 0;
        while (ctl_index !== 8'd2 && n < 500) begin @(negedge aclk); n++; end
        total++; if (ctl_index !== 8'd2) begin bad++; $display("FAIL b2b_index2 got=%0d exp=2", ctl_index); end
        ctl_enable = 1'b0;
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge aclk); n++;
            if (tvalid && st_log.size() == 31) begin
                found = 1'b1;
                total++; if (ctl_busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_last got=%0b exp=1", ctl_busy); end
                @(negedge aclk);
                total++; if (ctl_busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_fall got=%0b exp=0", ctl_busy); end
            end
        end
        total++; if (!found) begin bad++; $display("FAIL b2b_last_beat not seen, beats=%0d exp 32", st_log.size()); end
        repeat (20) @(negedge aclk);
        total++; if (ar_log.size() != 8 || st_log.size() != 32) begin bad++; $display("FAIL b2b_counts ar=%0d beats=%0d exp 8/32", ar_log.size(), st_log.size()); end
        total++; if (monitor_addr !== 32'h2000 || ctl_index !== 8'd2) begin bad++; $display("FAIL b2b_final mon_addr=%h index=%0d exp 2000/2", monitor_addr, ctl_index); end
        for (int i = 0; i < exp_ar.size(); i++) begin
            got = (i < ar_log.size()) ? ar_log[i] : 32'hxxxxxxxx;
            total++; if (got !== exp_ar[i]) begin bad++; $display("FAIL b2b_ar[%0d] got=%h exp=%h", i, got, exp_ar[i]); end
        end
        for (int i = 0; i < exp_st.size(); i++) begin
            gb = (i < st_log.size()) ? st_log[i] : 'x;
            total++; if (gb !== exp_st[i]) begin bad++; $display("FAIL b2b_beat[%0d] got=%h exp=%h", i, gb, exp_st[i]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit found;
        int n;
        beat_t e;
        clear_logs();
        set_params(32'h1000, 14'h100, 12'd8, 12'd2, 8'd3);
        @(negedge aclk); ctl_enable = 1'b1; ctl_update = 1'b1;
        found = 1'b0;
        n = 0;
        while (!found && n < 500) begin
            @(negedge aclk); n++;
            if (tvalid && st_log.size() == 5) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL midrst_beat5 not seen, beats=%0d", st_log.size()); end
        aresetn = 1'b0;
        #1;
        total++; if (ctl_busy !== 1'b0 || ctl_index !== 8'd0) begin bad++; $display("FAIL midrst_ctl busy=%0b index=%0d exp 0/0", ctl_busy, ctl_index); end
        total++; if ({arvalid, tvalid, tuser, tlast} !== 4'b0000) begin bad++; $display("FAIL midrst_valids got=%b exp=0000", {arvalid, tvalid, tuser, tlast}); end
        total++; if (rready !== 1'b1 || araddr !== 32'h0 || tdata !== 32'h0 || monitor_addr !== 32'h0) begin bad++; $display("FAIL midrst_regs rready=%0b araddr=%h tdata=%h mon=%h", rready, araddr, tdata, monitor_addr); end
        @(negedge aclk);
        clear_logs();
        aresetn = 1'b1;
        @(negedge aclk);
        total++; if (ctl_busy !== 1'b1 || ctl_index !== 8'd1) begin bad++; $display("FAIL midrst_restart busy=%0b index=%0d exp 1/1", ctl_busy, ctl_index); end
        ctl_enable = 1'b0; ctl_update = 1'b0;
        wait_idle("midrst_done");
        e.user = 1'b1; e.last = 1'b0; e.data = mk(32'h1000);
        total++; if (ar_log.size() != 4 || st_log.size() != 16) begin bad++; $display("FAIL midrst_counts ar=%0d beats=%0d exp 4/16", ar_log.size(), st_log.size()); end
        total++; if (ar_log.size() == 0 || ar_log[0] !== 32'h1000) begin bad++; $display("FAIL midrst_first_ar got=%h exp=1000", (ar_log.size() > 0) ? ar_log[0] : 32'hx); end
        total++; if (st_log.size() == 0 || st_log[0] !== e) begin bad++; $display("FAIL midrst_first_beat got=%h exp=%h", (st_log.size() > 0) ? st_log[0] : beat_t'('x), e); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        aresetn = 1'b0; ctl_enable = 1'b0; ctl_update = 1'b0;
        ar_rand = 1'b0; st_rand = 1'b0;
        set_params(32'h0, 14'h0, 12'h0, 12'h0, 8'h0);
        test_reset();
        test_basic();
        test_random_ready();
        test_single_beat();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
